check_scoreboard: RTL and testbench

//  Downstream consumer of the instruction checker. Tracks every issued instruction
//  (inst/pcEn) through a LATENCY-deep tag pipeline, aligns it with the checker's

---
 rtl/check_scoreboard_if.sv | 26 ++
 rtl/check_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_check_scoreboard.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/check_scoreboard_if.sv
// -----------------------------------------------------------------------------
// check_scoreboard_if
//   Issue/verdict stream between the instruction checker side and the
//   scoreboard.
//
//   Handshake: pcEn is a valid-only strobe (there is no ready). A word on
//   inst is taken in any cycle where pcEn=1 and the scoreboard is running.
//   OpDone is the checker's verdict for the word issued LATENCY cycles
//   earlier; it is only looked at while that word's tag is valid.
//
//   Signals
//     pcEn    : instruction issued this cycle
//     inst    : 32-bit issued instruction word
//     OpDone  : checker verdict, 1 = result matched
//   Modports
//     master  : drives the stream (checker / testbench)
//     slave   : consumes the stream (scoreboard)
// -----------------------------------------------------------------------------
interface check_scoreboard_if;
  logic        pcEn;
  logic [31:0] inst;
  logic        OpDone;

  modport master (output pcEn, output inst, output OpDone);
  modport slave  (input  pcEn, input  inst, input  OpDone);
endinterface

// File: rtl/check_scoreboard.sv
// -----------------------------------------------------------------------------
// check_scoreboard
//   Follows every issued instruction through a LATENCY-deep tag pipe, pairs it
//   with the checker's OpDone verdict and keeps saturating pass/fail/issued
//   statistics. The first failing instruction word is captured. A run is
//   controlled by start/stop; a watchdog ends the run after TIMEOUT
//   consecutive RUN cycles without an issue.
//
//   Ports
//     clk             : clock, all state on posedge
//     reset           : asynchronous, active-low reset
//     start           : IDLE/DONE -> RUN, zeroes statistics
//     stop            : RUN -> DRAIN
//     clear           : synchronous return to IDLE, statistics zeroed
//     chk_if          : issue/verdict stream (pcEn, inst, OpDone)
//     pass_cnt        : verdicts with OpDone=1
//     fail_cnt        : verdicts with OpDone=0
//     issued_cnt      : instructions accepted into the tag pipe
//     first_fail_inst : word of the first failing verdict
//     first_fail_vld  : first_fail_inst is valid
//     busy            : state is RUN or DRAIN
//     done            : state is DONE
//     timeout         : last run ended through the watchdog (sticky)
//     state_dbg       : current state encoding (0 IDLE,1 RUN,2 DRAIN,3 DONE)
// -----------------------------------------------------------------------------
module check_scoreboard #(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  check_scoreboard_if.slave    chk_if,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     issued_cnt,
  output logic [31:0]          first_fail_inst,
  output logic                 first_fail_vld,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [1:0]           state_dbg
);

  localparam int DRN_W = $clog2(LATENCY + 1);
  localparam int IDL_W = $clog2(TIMEOUT + 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LATENCY - 1);
  localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LATENCY-1:0] vld_q;
  logic [31:0]      inst_q [LATENCY];
  logic [DRN_W-1:0] drain_q;
  logic [IDL_W-1:0] idle_q;

  logic start_ok;
  logic issue;
  logic verdict;
  logic wd_fire;

  always_comb begin
    start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    issue    = chk_if.pcEn & (state_q == S_RUN) & ~clear;
    verdict  = vld_q[LATENCY-1] & ((state_q == S_RUN) | (state_q == S_DRAIN)) & ~clear;
    // The watchdog fires on the edge that would count the TIMEOUT-th idle
    // cycle. An explicit stop in the same cycle takes the credit instead.
    wd_fire  = (state_q == S_RUN) & ~chk_if.pcEn & (idle_q == IDL_LAST) & ~stop & ~clear;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (stop || wd_fire) state_d = S_DRAIN;
      // No tag is loaded in DRAIN, so after LATENCY shifts the pipe is empty.
      S_DRAIN: if (drain_q == DRN_LAST) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Tag pipe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) inst_q[i] <= '0;
    end else begin
      vld_q[0]  <= issue;
      inst_q[0] <= chk_if.inst;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        inst_q[i] <= inst_q[i-1];
      end
      if (clear) vld_q <= '0;
    end
  end

  // Drain and idle counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_q <= '0;
      idle_q  <= '0;
    end else begin
      if (state_q == S_DRAIN) drain_q <= drain_q + DRN_W'(1);
      else                    drain_q <= '0;

      if (clear || start_ok || state_q != S_RUN) idle_q <= '0;
      else if (chk_if.pcEn)                      idle_q <= '0;
      else if (idle_q != IDL_LAST)               idle_q <= idle_q + IDL_W'(1);
    end
  end

  // Statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      issued_cnt      <= '0;
      first_fail_inst <= '0;
      first_fail_vld  <= 1'b0;
      timeout         <= 1'b0;
    end else if (clear || start_ok) begin
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      issued_cnt      <= '0;
      first_fail_inst <= '0;
      first_fail_vld  <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      if (issue && issued_cnt != CNT_MAX) issued_cnt <= issued_cnt + CNT_W'(1);
      if (verdict) begin
        if (chk_if.OpDone) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
          if (!first_fail_vld) begin
            first_fail_inst <= inst_q[LATENCY-1];
            first_fail_vld  <= 1'b1;
          end
        end
      end
      if (wd_fire) timeout <= 1'b1;
    end
  end

  always_comb begin
    busy      = (state_q == S_RUN) | (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_check_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_check_scoreboard
//   Drives two scoreboards (CNT_W=16 and CNT_W=4) from one issue stream.
//   Every tracked issue pushes {due cycle, verdict, inst} onto exp_q and
//   schedules its OpDone LATENCY cycles later; a monitor pops an entry each
//   time the 16-bit instance records a verdict.
// -----------------------------------------------------------------------------
module tb_check_scoreboard;

  localparam int LAT = 3;

  logic clk;
  logic reset;
  logic start, stop, clear;

  check_scoreboard_if ifc ();

  logic [15:0] p16, f16, i16;
  logic [31:0] ffi16;
  logic        ffv16, busy16, done16, to16;
  logic [1:0]  st16;

  logic [3:0]  p4, f4, i4;
  logic [31:0] ffi4;
  logic        ffv4, busy4, done4, to4;
  logic [1:0]  st4;

  check_scoreboard #(.LATENCY(LAT), .CNT_W(16), .TIMEOUT(64)) dut16 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .chk_if(ifc.slave),
    .pass_cnt(p16), .fail_cnt(f16), .issued_cnt(i16),
    .first_fail_inst(ffi16), .first_fail_vld(ffv16),
    .busy(busy16), .done(done16), .timeout(to16), .state_dbg(st16)
  );

  check_scoreboard #(.LATENCY(LAT), .CNT_W(4), .TIMEOUT(64)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .chk_if(ifc.slave),
    .pass_cnt(p4), .fail_cnt(f4), .issued_cnt(i4),
    .first_fail_inst(ffi4), .first_fail_vld(ffv4),
    .busy(busy4), .done(done4), .timeout(to4), .state_dbg(st4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- check / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [64:0] exp_q[$];     // {due cycle[31:0], ok, inst[31:0]}
  bit          od_at[int unsigned];
  bit          ff_seen = 0;
  int          prev_p = 0, prev_f = 0;

  // OpDone: scheduled verdict where one is due, noise everywhere else.
  always @(negedge clk) begin
    if (od_at.exists(cyc)) ifc.OpDone = od_at[cyc];
    else                   ifc.OpDone = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [64:0] e;
    int np, nf;
    np = int'(p16);
    nf = int'(f16);
    if (np + nf > prev_p + prev_f) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_verdict", 32'(np + nf), 32'(prev_p + prev_f));
      end else begin
        e = exp_q.pop_front();
        chk("verdict_cycle", cyc, e[64:33]);
        chk("verdict_pass_step", 32'(np - prev_p), {31'd0, e[32]});
        chk("verdict_fail_step", 32'(nf - prev_f), {31'd0, ~e[32]});
        if (!e[32] && !ff_seen) begin
          ff_seen = 1;
          chk("first_fail_capture", ffi16, e[31:0]);
          chk("first_fail_vld_set", {31'd0, ffv16}, 32'd1);
        end
      end
    end
    prev_p = np;
    prev_f = nf;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic sp, input logic cl,
                       input logic pe, input logic [31:0] in);
    @(negedge clk);
    start    = st;
    stop     = sp;
    clear    = cl;
    ifc.pcEn = pe;
    ifc.inst = in;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_start();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    ff_seen = 0;
  endtask

  task automatic do_stop();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic issue(input logic [31:0] in, input logic ok,
                       input logic tracked, input logic with_stop);
    drive(1'b0, with_stop, 1'b0, 1'b1, in);
    if (tracked) begin
      exp_q.push_back({cyc + 32'd4, ok, in});
      od_at[cyc + 32'd3] = ok;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done16 && n < 16) begin
      idle(1);
      n++;
    end
    chk(tag, {31'd0, done16}, 32'd1);
  endtask

  task automatic chk_zero16(input string tag);
    chk({tag, "_pass"},   32'(p16), 32'd0);
    chk({tag, "_fail"},   32'(f16), 32'd0);
    chk({tag, "_issued"}, 32'(i16), 32'd0);
    chk({tag, "_ffi"},    ffi16, 32'd0);
    chk({tag, "_ffv"},    {31'd0, ffv16}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy16}, 32'd0);
    chk({tag, "_done"},   {31'd0, done16}, 32'd0);
    chk({tag, "_timeout"},{31'd0, to16}, 32'd0);
    chk({tag, "_state"},  {30'd0, st16}, 32'd0);
  endtask

  logic [31:0] t3_inst [4];
  logic        t3_ok   [4];

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; start = 0; stop = 0; clear = 0;
    ifc.pcEn = 0; ifc.inst = '0;
    t3_inst[0] = 32'h0022_1820; t3_ok[0] = 1;
    t3_inst[1] = 32'h8C01_0004; t3_ok[1] = 0;
    t3_inst[2] = 32'h1022_0003; t3_ok[2] = 1;
    t3_inst[3] = 32'h0800_0010; t3_ok[3] = 0;

    idle(3);
    @(negedge clk) reset = 1'b1;
    idle(1);
    chk_zero16("reset");
    chk("reset_dut4_pass", 32'(p4), 32'd0);

    // T1: asynchronous reset with two tags in flight
    do_start();
    issue(32'hAAAA_0001, 1'b1, 1'b1, 1'b0);
    issue(32'hAAAA_0002, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("t1_issued_before", 32'(i16), 32'd2);
    chk("t1_state_run", {30'd0, st16}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_zero16("t1_async");
    exp_q.delete();
    od_at.delete();
    @(negedge clk) reset = 1'b1;
    idle(5);
    chk_zero16("t1_after");

    // T2: five passing issues, then stop
    do_start();
    idle(1);
    chk("t2_busy", {31'd0, busy16}, 32'd1);
    for (int i = 0; i < 5; i++) issue($urandom, 1'b1, 1'b1, 1'b0);
    idle(4);
    do_stop();
    idle(3);
    chk("t2_drain_state", {30'd0, st16}, 32'd2);
    idle(1);
    chk("t2_done_latency", {31'd0, done16}, 32'd1);
    wait_done("t2_wait_done");
    chk("t2_pass", 32'(p16), 32'd5);
    chk("t2_fail", 32'(f16), 32'd0);
    chk("t2_issued", 32'(i16), 32'd5);
    chk("t2_ffv", {31'd0, ffv16}, 32'd0);
    chk("t2_busy_done", {31'd0, busy16}, 32'd0);

    // T3: two failing verdicts, first capture kept
    do_start();
    for (int i = 0; i < 4; i++) issue(t3_inst[i], t3_ok[i], 1'b1, 1'b0);
    do_stop();
    wait_done("t3_wait_done");
    chk("t3_pass", 32'(p16), 32'd2);
    chk("t3_fail", 32'(f16), 32'd2);
    chk("t3_issued", 32'(i16), 32'd4);
    chk("t3_ffi", ffi16, 32'h8C01_0004);
    chk("t3_ffv", {31'd0, ffv16}, 32'd1);

    // T4: issue together with stop is tracked; issue during DRAIN is not
    do_start();
    idle(2);
    issue($urandom, 1'b1, 1'b1, 1'b1);
    issue($urandom, 1'b0, 1'b0, 1'b0);
    issue($urandom, 1'b0, 1'b0, 1'b0);
    wait_done("t4_wait_done");
    idle(4);
    chk("t4_issued", 32'(i16), 32'd1);
    chk("t4_pass", 32'(p16), 32'd1);
    chk("t4_fail", 32'(f16), 32'd0);

    // T5: watchdog
    do_start();
    idle(64);
    chk("t5_still_run", {30'd0, st16}, 32'd1);
    chk("t5_no_timeout_yet", {31'd0, to16}, 32'd0);
    idle(1);
    chk("t5_drain", {30'd0, st16}, 32'd2);
    chk("t5_timeout", {31'd0, to16}, 32'd1);
    idle(2);
    chk("t5_not_done_yet", {31'd0, done16}, 32'd0);
    idle(1);
    chk("t5_done", {31'd0, done16}, 32'd1);
    chk("t5_timeout_sticky", {31'd0, to16}, 32'd1);
    do_start();
    idle(1);
    chk("t5_timeout_cleared", {31'd0, to16}, 32'd0);
    chk("t5_rerun", {30'd0, st16}, 32'd1);
    do_stop();
    wait_done("t5_wait_done");
    chk("t5_stop_no_timeout", {31'd0, to16}, 32'd0);

    // T6: saturation on the narrow instance, then clear (beats start)
    do_start();
    for (int i = 0; i < 20; i++) issue($urandom, 1'b1, 1'b1, 1'b0);
    do_stop();
    wait_done("t6_wait_done");
    chk("t6_pass16", 32'(p16), 32'd20);
    chk("t6_issued16", 32'(i16), 32'd20);
    chk("t6_pass4_sat", 32'(p4), 32'd15);
    chk("t6_issued4_sat", 32'(i4), 32'd15);
    chk("t6_fail4", 32'(f4), 32'd0);
    chk("t6_done4", {31'd0, done4}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(1);
    chk_zero16("t6_clear");
    chk("t6_clear_pass4", 32'(p4), 32'd0);
    chk("t6_clear_issued4", 32'(i4), 32'd0);
    chk("t6_clear_state4", {30'd0, st4}, 32'd0);
    chk("t6_clear_busy4", {31'd0, busy4}, 32'd0);

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
